// File: rtl/result_tx.sv
// Byte-serial result transmitter: captures a golden nonce and hash and streams them as a framed byte sequence.
// Optional trailing XOR checksum byte is built when RESULT_TX_CHECKSUM_EN is defined.
module result_tx #(
   parameter int HASH_BYTES = 32
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         found,
   input  logic [31:0]  nonce_in,
   input  logic [255:0] hash_in,
   input  logic         tx_ready,
   output logic         tx_valid,
   output logic [7:0]   tx_data,
   output logic         busy,
   output logic         tx_done,
   output logic         overrun
);

`ifdef RESULT_TX_CHECKSUM_EN
   localparam int CSUM_BYTES = 1;
`else
   localparam int CSUM_BYTES = 0;
`endif
   localparam logic [5:0] LAST_IDX = 6'(4 + HASH_BYTES + CSUM_BYTES);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t       state_q, state_d;
   logic [5:0]   cnt_q;
   logic [31:0]  nonce_q;
   logic [255:0] hash_q;
   logic         ovr_q;
   logic         accept, xfer, last_byte;

   // Sync byte, nonce and hash laid out as one frame image; every byte index maps to a fixed slice.
   function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic [31:0] n,
                                             input logic [255:0] h);
      logic [295:0] f;
      f = {8'hA5, n, h};
      frame_byte = 8'h00;
      for (int i = 0; i < 37; i++) begin
         if (idx == 6'(i)) frame_byte = f[295-8*i -: 8];
      end
   endfunction

`ifdef RESULT_TX_CHECKSUM_EN
   logic [7:0] csum_q;

   function automatic logic [7:0] calc_csum(input logic [31:0] n, input logic [255:0] h);
      logic [7:0] c;
      c = n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
      for (int i = 0; i < HASH_BYTES; i++) c = c ^ h[255-8*i -: 8];
      return c;
   endfunction

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)      csum_q <= 8'h00;
      else if (accept) csum_q <= calc_csum(nonce_in, hash_in);
   end
`endif

   assign accept    = found && (state_q == IDLE);
   assign xfer      = (state_q == SEND) && tx_ready;
   assign last_byte = (cnt_q == LAST_IDX);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = SEND;
         SEND:    if (tx_ready && last_byte) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture, byte counter and sticky overrun; found outside IDLE (DONE included) is dropped.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q   <= 6'd0;
         nonce_q <= 32'h0;
         hash_q  <= 256'h0;
         ovr_q   <= 1'b0;
      end else if (accept) begin
         cnt_q   <= 6'd0;
         nonce_q <= nonce_in;
         hash_q  <= hash_in;
         ovr_q   <= 1'b0;
      end else begin
         if (found) ovr_q <= 1'b1;
         if (xfer && !last_byte) cnt_q <= cnt_q + 6'd1;
      end
   end

   always_comb begin
      tx_data = 8'h00;
      if (state_q == SEND) begin
         tx_data = frame_byte(cnt_q, nonce_q, hash_q);
`ifdef RESULT_TX_CHECKSUM_EN
         if (last_byte) tx_data = csum_q;
`endif
      end
   end

   assign tx_valid = (state_q == SEND);
   assign busy     = (state_q != IDLE);
   assign tx_done  = (state_q == DONE);
   assign overrun  = ovr_q;

endmodule

// File: tb/tb_result_tx.sv
// Self-checking bench for result_tx (HASH_BYTES=2): frame-queue model compared every cycle plus literal frames.
module tb_result_tx;
   localparam int HB = 2;
`ifdef RESULT_TX_CHECKSUM_EN
   localparam int L = 6 + HB;
`else
   localparam int L = 5 + HB;
`endif

   logic         clk = 1'b0;
   logic         n_rst = 1'b0;
   logic         found = 1'b0;
   logic [31:0]  nonce_in = 32'h0;
   logic [255:0] hash_in = 256'h0;
   logic         tx_ready = 1'b0;
   logic         tx_valid, busy, tx_done, overrun;
   logic [7:0]   tx_data;

   int total = 0;
   int bad = 0;

   logic [7:0] mq[$];
   bit         m_done = 1'b0;
   bit         m_ovr = 1'b0;
   logic [7:0] cur[$];
   logic [7:0] got[$];
   logic [7:0] exp_f[$];
   int         done_cnt = 0;

   result_tx #(.HASH_BYTES(HB)) dut (
      .clk(clk), .n_rst(n_rst), .found(found), .nonce_in(nonce_in), .hash_in(hash_in),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy),
      .tx_done(tx_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void build_frame(input logic [31:0] n, input logic [255:0] h);
      logic [7:0] b, c;
      c = 8'h00;
      mq.push_back(8'hA5);
      for (int i = 0; i < 4; i++) begin
         b = 8'((n >> (24 - 8*i)) & 32'hFF);
         mq.push_back(b);
         c = c ^ b;
      end
      for (int i = 0; i < HB; i++) begin
         b = 8'((h >> (248 - 8*i)) & 256'hFF);
         mq.push_back(b);
         c = c ^ b;
      end
`ifdef RESULT_TX_CHECKSUM_EN
      mq.push_back(c);
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      m_done = 1'b0;
      m_ovr  = 1'b0;
      cur.delete();
   endtask

   task automatic model_update();
      if (!n_rst) model_reset();
      else if (m_done) begin
         m_done = 1'b0;
         if (found) m_ovr = 1'b1;
      end else if (mq.size() != 0) begin
         if (found) m_ovr = 1'b1;
         if (tx_ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_done = 1'b1;
         end
      end else if (found) begin
         build_frame(nonce_in, hash_in);
         m_ovr = 1'b0;
      end
   endtask

   task automatic compare();
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, mq.size() != 0});
      chk("tx_data", {24'b0, tx_data}, {24'b0, (mq.size() != 0) ? mq[0] : 8'h00});
      chk("busy", {31'b0, busy}, {31'b0, (mq.size() != 0) || m_done});
      chk("tx_done", {31'b0, tx_done}, {31'b0, m_done});
      chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
      if (!n_rst) cur.delete();
      else if (tx_valid && tx_ready) cur.push_back(tx_data);
      if (tx_done) begin
         got = cur;
         cur.delete();
         done_cnt++;
      end
   endtask

   // One cycle: compare at the falling edge, advance the model at the rising edge, return just after it.
   task automatic step();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic wait_done(input int max_cyc, output int n);
      int start;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < max_cyc) begin
         step();
         n++;
      end
      if (done_cnt == start) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_frame(input string nm);
      chk({nm, "_len"}, got.size(), exp_f.size());
      for (int i = 0; i < exp_f.size(); i++)
         chk(nm, (i < got.size()) ? {24'b0, got[i]} : 32'hFFFF_FFFF, {24'b0, exp_f[i]});
   endtask

   task automatic send_found(input logic [31:0] n, input logic [255:0] h);
      found = 1'b1;
      nonce_in = n;
      hash_in = h;
      step();
      found = 1'b0;
      nonce_in = $urandom();
      hash_in = {8{$urandom()}};
   endtask

   initial begin
      int n;
      logic [255:0] h_dead, h_0102;
      h_dead = {16'hDEAD, {15{16'h5A3C}}};
      h_0102 = {16'h0102, {15{16'hC3F0}}};

      // Reset with found held high
      found = 1'b1;
      nonce_in = 32'hCAFEF00D;
      hash_in = h_dead;
      repeat (3) step();
      chk("rst_valid", {31'b0, tx_valid}, 32'd0);
      chk("rst_data", {24'b0, tx_data}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, tx_done}, 32'd0);
      chk("rst_ovr", {31'b0, overrun}, 32'd0);
      found = 1'b0;
      n_rst = 1'b1;
      repeat (3) step();
      chk("post_rst_busy", {31'b0, busy}, 32'd0);

      // Basic frame, tx_ready held high
      tx_ready = 1'b1;
      send_found(32'h12345678, h_dead);
      chk("lat_valid", {31'b0, tx_valid}, 32'd1);
      chk("lat_data", {24'b0, tx_data}, 32'hA5);
      wait_done(60, n);
      chk("done_lat", n, L + 1);
      exp_f = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD};
`ifdef RESULT_TX_CHECKSUM_EN
      exp_f.push_back(8'h7B);
`endif
      check_frame("frame_basic");

      // tx_ready pattern 1,0,0,1 repeating
      send_found(32'h12345678, h_dead);
      for (int i = 0; i < 80 && done_cnt == 1; i++) begin
         tx_ready = (i % 4 == 0) || (i % 4 == 3);
         step();
      end
      chk("toggle_done", done_cnt, 32'd2);
      check_frame("frame_toggle");
      tx_ready = 1'b1;

      // found during a frame is dropped; next accepted found clears overrun
      send_found(32'h12345678, h_dead);
      repeat (2) step();
      found = 1'b1;
      nonce_in = 32'hFFFFFFFF;
      hash_in = {16'hBEEF, 240'h0};
      step();
      found = 1'b0;
      wait_done(60, n);
      check_frame("frame_ovr");
      chk("ovr_set", {31'b0, overrun}, 32'd1);
      step();
      chk("ovr_hold", {31'b0, overrun}, 32'd1);
      send_found(32'hAABBCCDD, h_0102);
      chk("ovr_clr", {31'b0, overrun}, 32'd0);
      wait_done(60, n);
      exp_f = '{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02};
`ifdef RESULT_TX_CHECKSUM_EN
      exp_f.push_back(8'h03);
`endif
      check_frame("frame_new");

      // found in the DONE cycle is dropped
      send_found(32'h0BADF00D, h_0102);
      repeat (L) step();
      found = 1'b1;
      step();
      found = 1'b0;
      chk("done_seen", done_cnt, 32'd5);
      step();
      chk("done_drop_busy", {31'b0, busy}, 32'd0);
      chk("done_drop_ovr", {31'b0, overrun}, 32'd1);

      // Reset asserted after the third byte transfers
      send_found(32'h12345678, h_dead);
      repeat (3) step();
      n_rst = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_done", {31'b0, tx_done}, 32'd0);
      model_reset();
      repeat (2) step();
      n_rst = 1'b1;
      step();
      send_found(32'h12345678, h_dead);
      wait_done(60, n);
      exp_f = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD};
`ifdef RESULT_TX_CHECKSUM_EN
      exp_f.push_back(8'h7B);
`endif
      check_frame("frame_after_rst");
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/result_tx.md
# result_tx

Byte-serial result transmitter for the miner's host link. When the hashing core reports a golden nonce, this block captures the nonce and the resulting hash and streams them to the host interface as a framed byte sequence over a valid/ready handshake. It is the outbound counterpart to the inbound work-shift path, which loads the midstate and remaining words into the core.

## Interface
Parameters:
- HASH_BYTES, default 32: number of hash bytes sent per frame, legal range 0..32, taken from the most-significant end of hash_in.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- n_rst  input  1  asynchronous active-low reset
- found  input  1  single-cycle pulse: the core found a nonce; sampled only in IDLE
- nonce_in  input  32  golden nonce; valid in the cycle found is high
- hash_in  input  256  final hash; valid in the cycle found is high
- tx_ready  input  1  host link accepts a byte this cycle
- tx_valid  output  1  tx_data holds a valid byte
- tx_data  output  8  current frame byte
- busy  output  1  high when state is not IDLE
- tx_done  output  1  one-cycle pulse after the last byte of a frame has transferred
- overrun  output  1  sticky flag: a found pulse arrived while busy and was dropped

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- States: IDLE, SEND, DONE.
- IDLE: found=1 latches nonce_in and hash_in into internal registers, clears the byte counter, clears overrun, and moves the FSM to SEND.
- SEND: tx_valid=1. tx_data is selected by a 6-bit byte counter.
  - Frame order: sync byte 0xA5; nonce bytes MSB first (nonce[31:24] through nonce[7:0]); then HASH_BYTES hash bytes MSB first (hash[255:248] first); then the checksum byte when it is compiled in (see Configuration).
  - A byte transfers on a rising edge where tx_valid and tx_ready are both 1. The counter then increments.
  - On transfer of the last byte, the FSM moves to DONE.
- DONE: lasts one cycle. tx_done=1 and tx_valid=0. The FSM then returns to IDLE.
- found pulses outside IDLE, including in DONE, are dropped and set overrun=1. overrun stays set until the next accepted found.
- Frame length L = 5 + HASH_BYTES, or 6 + HASH_BYTES with the checksum compiled in.

## Timing
- Reset values: tx_valid=0, tx_data=8'h00, busy=0, tx_done=0, overrun=0, FSM in IDLE, byte counter=0, capture registers all zero.
- Reset asserted mid-frame returns the block to IDLE immediately. The frame is abandoned, and no tx_done is issued.
- found sampled at edge k: tx_valid=1 with tx_data=8'hA5 and busy=1 from cycle k+1.
- With tx_ready held high, one byte transfers per cycle. The last byte transfers at edge k+L, tx_done=1 during cycle k+L+1, and IDLE is reached at cycle k+L+2. The earliest next accepted found is at edge k+L+2.
- While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. tx_valid never drops mid-frame.
- tx_ready is ignored when tx_valid=0.
- A found pulse in the same cycle that DONE returns to IDLE is dropped and sets overrun.
- nonce_in and hash_in may change freely after the capture edge.

## Configuration
- RESULT_TX_CHECKSUM_EN defined: one extra byte is appended after the hash bytes. Its value is the XOR of all nonce and hash bytes sent; the sync byte is excluded.
- RESULT_TX_CHECKSUM_EN undefined: no checksum logic is built, and the frame ends on the last hash byte.

## Test plan
- Reset with found=1 held during reset: all outputs match the reset values, and no frame starts until the first found edge after n_rst is released.
- HASH_BYTES=2, checksum off, nonce_in=32'h12345678, hash_in[255:240]=16'hDEAD, tx_ready=1: the bytes are A5 12 34 56 78 DE AD on 7 consecutive cycles, then tx_done pulses once.
- Same stimulus with RESULT_TX_CHECKSUM_EN defined: the bytes are A5 12 34 56 78 DE AD 7B.
- tx_ready toggling 1,0,0,1,… on the same stimulus: each byte is held stable while tx_ready=0, no byte is duplicated or skipped, and tx_done fires one cycle after the final handshake.
- found pulsed again 3 cycles into a frame: the frame completes unchanged, overrun=1 persists, and the next found in IDLE clears overrun and sends a new frame.
- n_rst asserted after the third byte: tx_valid=0 and busy=0 immediately with no tx_done, and a subsequent found sends a complete frame starting at 0xA5.
